prv32_alu_arb: RTL and testbench
================================

Name: prv32_alu_arb

Overview:
- Arbiter that shares one prv32_ALU instance between two requesters.
- Port 0 is the core execute path; port 1 is a secondary client, e.g. a multicycle or CSR/debug unit.
- Handles valid/ready request handshakes, round-robin grants and a 1-cycle ALU issue.
- Holds each port's result in a one-deep response register until that port consumes it.

Parameters:
- NREQ, 2, number of requesters; fixed at 2, other values are illegal.
- XLEN, 32, operand/result width; must match prv32_ALU.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  2  per-port request valid (bit i = port i).
- req_ready  out  2  per-port request accepted this cycle (combinational).
- req_a  in  2*XLEN  operand a per port; port i at [i*XLEN +: XLEN].
- req_b  in  2*XLEN  operand b per port.
- req_shamt  in  10  shift amount per port, 5 bits each.
- req_alufn  in  8  ALU function per port, 4 bits each, `ALU_* encodings.
- rsp_valid  out  2  per-port response valid.
- rsp_ready  in  2  per-port response consumed.
- rsp_r  out  2*XLEN  per-port result.
- rsp_flags  out  8  per-port {cf,zf,vf,sf}.
- busy_cnt  out  16  saturating count of cycles where both ports requested and one was stalled.

Behaviour:
- Reset: rsp_valid=0, rsp_r=0, rsp_flags=0, busy_cnt=0, rr_last=1 (port 0 wins the first contention).
- Reset is async: asserting it mid-transaction drops in-flight and held responses; no partial results survive.
- Eligibility: elig[i] = req_valid[i] && (!rsp_valid[i] || rsp_ready[i]). A full response slot accepts a new request only in the cycle it is drained.
- Grant (one-hot or zero):
  - Only one eligible port: grant it.
  - Both eligible: grant the port != rr_last.
  - req_ready = grant.
  - rr_last updates to the granted port only when a grant occurs.
- Issue: the mux selects the granted port's a/b/shamt/alufn into prv32_ALU (combinational). At the clock edge, r and flags are captured into the granted port's response register and rsp_valid[g] is set.
  - Latency: request accepted in cycle N gives rsp_valid in cycle N+1.
  - Throughput: 1 op/cycle total.
- Response: rsp_r/rsp_flags stay stable while rsp_valid && !rsp_ready.
  - rsp_ready with rsp_valid and no new grant: rsp_valid clears next cycle.
  - Drain and new grant on the same port in the same cycle: rsp_valid stays 1 and data is replaced.
- No grant: ALU inputs are driven to 0, alufn = `ALU_ADD. Response registers are not written.
- busy_cnt: increments when req_valid==2'b11 && popcount(grant)==1; saturates at 16'hFFFF.
- Fairness: with both ports continuously valid and drained, grants strictly alternate; no port waits more than 1 cycle once eligible.
- rsp_ready with rsp_valid=0 is ignored.

Optional Feature:
- Macro: PRV32_ALU_ARB_PRIO0_EN.
- Defined: port 0 has strict fixed priority; port 1 is granted only when port 0 is not eligible. rr_last is still maintained but unused.
- Undefined: round-robin as above.

Decomposition:
- Shared defines.v (existing): `ALU_* alufn encodings, plus new ARB_PORT_EXE=0 and ARB_PORT_AUX=1 constants.
- One sub-module: prv32_alu_arb_rr, the 2-way round-robin grant logic (elig, rr_last → grant), replaced by the fixed-priority path under the macro.
- prv32_ALU is instantiated once, unmodified.

Test Plan:
- Reset release, port 0 sends a=5, b=7, `ALU_ADD, rsp_ready=1 → req_ready=01 same cycle; next cycle rsp_valid=01, rsp_r[0]=12, flags zf=0.
- Both ports valid every cycle (port 0 `ALU_SUB 3-3, port 1 `ALU_XOR F0^0F), rsp_ready=11 → grants 01,10,01,10; port 0 r=0 with zf=1; port 1 r=FF; busy_cnt increments once per cycle.
- Port 1 rsp_ready=0 holding result, port 1 issues again → req_ready[1]=0 until rsp_ready[1]=1. In that cycle the new grant is accepted and rsp_valid[1] stays 1 with new data. Port 0 is unaffected meanwhile.
- `ALU_SLT a=FFFFFFFF (−1), b=1 → r=1; `ALU_SLTU same operands → r=0; `ALU_SRA a=80000000, shamt=4 → F8000000.
- rst asserted mid-cycle with rsp_valid=11 → rsp_valid=00 and rsp_r=0 immediately (async). After release, first contention grants port 0.
- With PRV32_ALU_ARB_PRIO0_EN defined and both ports continuously valid/drained → port 1 never granted; port 1 is granted the cycle after port 0 deasserts.

Source files
------------

// File: rtl/prv32_alu_arb_pkg.sv
// Shared encodings for the prv32 ALU arbiter slice: ALU function codes,
// arbiter port indices and the packed flag bundle.
package prv32_alu_arb_pkg;

   localparam logic [3:0] ALU_ADD  = 4'b00_00;
   localparam logic [3:0] ALU_SUB  = 4'b00_01;
   localparam logic [3:0] ALU_PASS = 4'b00_11;
   localparam logic [3:0] ALU_OR   = 4'b01_00;
   localparam logic [3:0] ALU_AND  = 4'b01_01;
   localparam logic [3:0] ALU_XOR  = 4'b01_11;
   localparam logic [3:0] ALU_SRL  = 4'b10_00;
   localparam logic [3:0] ALU_SLL  = 4'b10_01;
   localparam logic [3:0] ALU_SRA  = 4'b10_10;
   localparam logic [3:0] ALU_SLT  = 4'b11_01;
   localparam logic [3:0] ALU_SLTU = 4'b11_11;

   localparam int ARB_PORT_EXE = 0;
   localparam int ARB_PORT_AUX = 1;

   typedef struct packed {
      logic cf;
      logic zf;
      logic vf;
      logic sf;
   } alu_flags_t;

endpackage

// File: rtl/prv32_ALU.sv
// Single-cycle prv32 ALU: add/sub, logic, shifts and set-less-than.
// Flags always come from the adder (subtract when alufn[0] is set).
module prv32_ALU
   import prv32_alu_arb_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [4:0]  shamt,
   input  logic [3:0]  alufn,
   output logic [31:0] r,
   output logic        cf,
   output logic        zf,
   output logic        vf,
   output logic        sf
);

   logic [31:0] op_b;
   logic [31:0] add;
   logic [31:0] sh;

   assign op_b      = alufn[0] ? ~b : b;
   assign {cf, add} = {1'b0, a} + {1'b0, op_b} + {32'd0, alufn[0]};
   assign zf        = ~|add;
   assign sf        = add[31];
   // carry into the msb xor carry out of it
   assign vf        = a[31] ^ op_b[31] ^ add[31] ^ cf;

   always_comb begin
      case (alufn[1:0])
         2'b01:   sh = a << shamt;
         2'b10:   sh = $signed(a) >>> shamt;
         default: sh = a >> shamt;
      endcase
   end

   always_comb begin
      r = '0;
      case (alufn)
         ALU_ADD, ALU_SUB: r = add;
         ALU_PASS:         r = b;
         ALU_OR:           r = a | b;
         ALU_AND:          r = a & b;
         ALU_XOR:          r = a ^ b;
         ALU_SRL, ALU_SLL,
         ALU_SRA:          r = sh;
         ALU_SLT:          r = {31'd0, sf ^ vf};
         ALU_SLTU:         r = {31'd0, ~cf};
         default:          r = '0;
      endcase
   end

endmodule

// File: rtl/prv32_alu_arb_rr.sv
// Two-way grant logic: round-robin away from the last winner, or strict
// port-0 priority when PRV32_ALU_ARB_PRIO0_EN is defined.
module prv32_alu_arb_rr
   import prv32_alu_arb_pkg::*;
(
   input  logic [1:0] elig_i,
   input  logic       rr_last_i,
   output logic [1:0] grant_o
);

`ifdef PRV32_ALU_ARB_PRIO0_EN
   logic unused_rr_last;
   assign unused_rr_last = rr_last_i;

   always_comb begin
      grant_o = 2'b00;
      if (elig_i[ARB_PORT_EXE])      grant_o = 2'b01;
      else if (elig_i[ARB_PORT_AUX]) grant_o = 2'b10;
   end
`else
   always_comb begin
      grant_o = 2'b00;
      case (elig_i)
         2'b01:   grant_o = 2'b01;
         2'b10:   grant_o = 2'b10;
         // contention: the port that did not win last time goes now
         2'b11:   grant_o = rr_last_i ? 2'b01 : 2'b10;
         default: grant_o = 2'b00;
      endcase
   end
`endif

endmodule

// File: rtl/prv32_alu_arb.sv
// Shares one prv32_ALU between the execute port and an auxiliary port, with a
// one-deep response register per port. PRV32_ALU_ARB_PRIO0_EN selects fixed priority.
module prv32_alu_arb
   import prv32_alu_arb_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int XLEN = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*XLEN-1:0] req_a,
   input  logic [NREQ*XLEN-1:0] req_b,
   input  logic [NREQ*5-1:0]    req_shamt,
   input  logic [NREQ*4-1:0]    req_alufn,
   output logic [NREQ-1:0]      rsp_valid,
   input  logic [NREQ-1:0]      rsp_ready,
   output logic [NREQ*XLEN-1:0] rsp_r,
   output logic [NREQ*4-1:0]    rsp_flags,
   output logic [15:0]          busy_cnt
);

   logic [NREQ-1:0][XLEN-1:0] a_v, b_v;
   logic [NREQ-1:0][4:0]      sh_v;
   logic [NREQ-1:0][3:0]      fn_v;

   assign a_v  = req_a;
   assign b_v  = req_b;
   assign sh_v = req_shamt;
   assign fn_v = req_alufn;

   logic [NREQ-1:0]           rsp_valid_q, rsp_valid_d;
   logic [NREQ-1:0][XLEN-1:0] rsp_r_q, rsp_r_d;
   logic [NREQ-1:0][3:0]      rsp_flags_q, rsp_flags_d;
   logic [15:0]               busy_q, busy_d;
   logic                      rr_last_q, rr_last_d;

   logic [NREQ-1:0] elig, grant;

   // a full slot can take a new request only in the cycle it drains
   assign elig = req_valid & (~rsp_valid_q | rsp_ready);

   prv32_alu_arb_rr u_rr (
      .elig_i    (elig),
      .rr_last_i (rr_last_q),
      .grant_o   (grant)
   );

   assign req_ready = grant;

   logic [XLEN-1:0] alu_a, alu_b, alu_r;
   logic [4:0]      alu_sh;
   logic [3:0]      alu_fn;
   alu_flags_t      alu_fl;

   always_comb begin
      alu_a  = '0;
      alu_b  = '0;
      alu_sh = '0;
      alu_fn = ALU_ADD;
      if (grant[ARB_PORT_EXE]) begin
         alu_a  = a_v[ARB_PORT_EXE];
         alu_b  = b_v[ARB_PORT_EXE];
         alu_sh = sh_v[ARB_PORT_EXE];
         alu_fn = fn_v[ARB_PORT_EXE];
      end else if (grant[ARB_PORT_AUX]) begin
         alu_a  = a_v[ARB_PORT_AUX];
         alu_b  = b_v[ARB_PORT_AUX];
         alu_sh = sh_v[ARB_PORT_AUX];
         alu_fn = fn_v[ARB_PORT_AUX];
      end
   end

   prv32_ALU u_alu (
      .a     (alu_a),
      .b     (alu_b),
      .shamt (alu_sh),
      .alufn (alu_fn),
      .r     (alu_r),
      .cf    (alu_fl.cf),
      .zf    (alu_fl.zf),
      .vf    (alu_fl.vf),
      .sf    (alu_fl.sf)
   );

   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_r_d     = rsp_r_q;
      rsp_flags_d = rsp_flags_q;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            rsp_valid_d[i] = 1'b1;
            rsp_r_d[i]     = alu_r;
            rsp_flags_d[i] = alu_fl;
         end else if (rsp_ready[i]) begin
            rsp_valid_d[i] = 1'b0;
         end
      end
   end

   always_comb begin
      busy_d = busy_q;
      if (&req_valid && $onehot(grant) && busy_q != 16'hFFFF)
         busy_d = busy_q + 16'd1;
      rr_last_d = (|grant) ? grant[ARB_PORT_AUX] : rr_last_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid_q <= '0;
         rsp_r_q     <= '0;
         rsp_flags_q <= '0;
         busy_q      <= '0;
         rr_last_q   <= 1'b1;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_r_q     <= rsp_r_d;
         rsp_flags_q <= rsp_flags_d;
         busy_q      <= busy_d;
         rr_last_q   <= rr_last_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_r     = rsp_r_q;
   assign rsp_flags = rsp_flags_q;
   assign busy_cnt  = busy_q;

endmodule

// File: tb/tb_prv32_alu_arb.sv
// Scoreboard bench for prv32_alu_arb: driver predicts grants and pushes
// expected results; a monitor pops and compares whenever a response is visible.
module tb_prv32_alu_arb;
   import prv32_alu_arb_pkg::*;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  sh;
      logic [3:0]  fn;
   } req_t;

   typedef struct packed {
      logic [3:0]  fl;
      logic [31:0] r;
   } rsp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  req_valid = '0;
   logic [1:0]  req_ready;
   logic [63:0] req_a = '0, req_b = '0;
   logic [9:0]  req_shamt = '0;
   logic [7:0]  req_alufn = '0;
   logic [1:0]  rsp_valid;
   logic [1:0]  rsp_ready = '0;
   logic [63:0] rsp_r;
   logic [7:0]  rsp_flags;
   logic [15:0] busy_cnt;

   prv32_alu_arb #(.NREQ(2), .XLEN(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_shamt (req_shamt),
      .req_alufn (req_alufn),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_r     (rsp_r),
      .rsp_flags (rsp_flags),
      .busy_cnt  (busy_cnt)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   rsp_t        exp_q[2][$];
   bit   [1:0]  m_full  = '0;
   bit          m_last  = 1'b1;
   int unsigned m_busy  = 0;
   bit          mon_en  = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic req_t mk(input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] sh, input logic [3:0] fn);
      req_t q;
      q.a = a; q.b = b; q.sh = sh; q.fn = fn;
      return q;
   endfunction

   // Reference ALU from plain integer arithmetic.
   function automatic rsp_t ref_alu(input req_t q);
      rsp_t            o;
      longint          sa, sb, sd;
      longint unsigned ua, ub;
      logic [31:0]     sum, res;
      bit              cf, vf;
      ua = 64'(q.a);
      ub = 64'(q.b);
      sa = longint'($signed(q.a));
      sb = longint'($signed(q.b));
      if (q.fn[0]) begin
         sum = q.a - q.b; cf = (ua >= ub); sd = sa - sb;
      end else begin
         sum = q.a + q.b; cf = ((ua + ub) > 64'hFFFF_FFFF); sd = sa + sb;
      end
      vf = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
      case (q.fn)
         ALU_ADD:  res = q.a + q.b;
         ALU_SUB:  res = q.a - q.b;
         ALU_PASS: res = q.b;
         ALU_OR:   res = q.a | q.b;
         ALU_AND:  res = q.a & q.b;
         ALU_XOR:  res = q.a ^ q.b;
         ALU_SRL:  res = q.a >> q.sh;
         ALU_SLL:  res = q.a << q.sh;
         ALU_SRA:  res = $signed(q.a) >>> q.sh;
         ALU_SLT:  res = (sa < sb) ? 32'd1 : 32'd0;
         ALU_SLTU: res = (ua < ub) ? 32'd1 : 32'd0;
         default:  res = '0;
      endcase
      o.r  = res;
      o.fl = {cf, sum == 32'd0, vf, sum[31]};
      return o;
   endfunction

   // One clock of stimulus; the expected grant follows the arbitration rules.
   task automatic cycle(input logic [1:0] v, input logic [1:0] rdy, input req_t r0, input req_t r1);
      logic [1:0] elig, g;
      @(negedge clk);
      req_valid = v;
      rsp_ready = rdy;
      req_a     = {r1.a, r0.a};
      req_b     = {r1.b, r0.b};
      req_shamt = {r1.sh, r0.sh};
      req_alufn = {r1.fn, r0.fn};
      #2;
      elig = v & (~m_full | rdy);
      if (elig == 2'b11) begin
`ifdef PRV32_ALU_ARB_PRIO0_EN
         g = 2'b01;
`else
         g = m_last ? 2'b01 : 2'b10;
`endif
      end else begin
         g = elig;
      end
      chk("req_ready", 64'(req_ready), 64'(g));
      chk("busy_cnt", 64'(busy_cnt), 64'(m_busy));
      if (v == 2'b11 && g != 2'b00 && m_busy < 32'hFFFF) m_busy++;
      for (int i = 0; i < 2; i++) begin
         if (g[i]) begin
            exp_q[i].push_back(ref_alu(i == 0 ? r0 : r1));
            m_full[i] = 1'b1;
         end else if (rdy[i]) begin
            m_full[i] = 1'b0;
         end
      end
      if (g != 2'b00) m_last = g[1];
   endtask

   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (mon_en) begin
            for (int i = 0; i < 2; i++) begin
               chk($sformatf("rsp_valid[%0d]", i), 64'(rsp_valid[i]), 64'(exp_q[i].size() != 0));
               if (rsp_valid[i] && exp_q[i].size() != 0) begin
                  chk($sformatf("rsp_r[%0d]", i), 64'(rsp_r[i*32 +: 32]), 64'(exp_q[i][0].r));
                  chk($sformatf("rsp_flags[%0d]", i), 64'(rsp_flags[i*4 +: 4]), 64'(exp_q[i][0].fl));
                  if (rsp_ready[i]) void'(exp_q[i].pop_front());
               end
            end
         end
      end
   end

   function automatic logic [31:0] rnd_op();
      case ($urandom_range(0, 3))
         0:       return 32'($urandom_range(0, 15));
         1:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
         2:       return 32'h8000_0000 ^ 32'($urandom_range(0, 15));
         default: return 32'($urandom);
      endcase
   endfunction

   logic [3:0] fns [11];
   req_t       idle, r0, r1;
   logic [1:0] exp_g [4];

   initial begin
      fns  = '{ALU_ADD, ALU_SUB, ALU_PASS, ALU_OR, ALU_AND, ALU_XOR,
               ALU_SRL, ALU_SLL, ALU_SRA, ALU_SLT, ALU_SLTU};
      idle = mk(32'd0, 32'd0, 5'd0, ALU_ADD);

      #12;
      chk("reset rsp_valid", 64'(rsp_valid), 64'h0);
      chk("reset rsp_r", rsp_r, 64'h0);
      chk("reset rsp_flags", 64'(rsp_flags), 64'h0);
      chk("reset busy_cnt", 64'(busy_cnt), 64'h0);
      @(negedge clk);
      rst    = 1'b0;
      mon_en = 1'b1;

      // single add on port 0
      cycle(2'b01, 2'b11, mk(32'd5, 32'd7, 5'd0, ALU_ADD), idle);
      chk("t1 req_ready", 64'(req_ready), 64'h1);
      cycle(2'b00, 2'b11, idle, idle);
      chk("t1 rsp_valid", 64'(rsp_valid), 64'h1);
      chk("t1 rsp_r", 64'(rsp_r[31:0]), 64'd12);
      chk("t1 zf", 64'(rsp_flags[2]), 64'h0);

      // port 1 holds its result; a second request waits until it drains
      cycle(2'b10, 2'b01, idle, mk(32'hAA, 32'h55, 5'd0, ALU_ADD));
      chk("hold grant1", 64'(req_ready), 64'h2);
      cycle(2'b10, 2'b01, idle, mk(32'd1, 32'd2, 5'd0, ALU_ADD));
      chk("hold stalled", 64'(req_ready), 64'h0);
      cycle(2'b11, 2'b01, mk(32'd9, 32'd6, 5'd0, ALU_OR), mk(32'd1, 32'd2, 5'd0, ALU_ADD));
      chk("hold port0 ok", 64'(req_ready), 64'h1);
      chk("hold data", 64'(rsp_r[63:32]), 64'hFF);
      cycle(2'b10, 2'b11, idle, mk(32'd1, 32'd2, 5'd0, ALU_ADD));
      chk("drain+grant", 64'(req_ready), 64'h2);
      cycle(2'b00, 2'b11, idle, idle);
      chk("replaced valid", 64'(rsp_valid[1]), 64'h1);
      chk("replaced data", 64'(rsp_r[63:32]), 64'd3);

      // signed/unsigned compare and arithmetic shift
      cycle(2'b01, 2'b11, mk(32'hFFFF_FFFF, 32'd1, 5'd0, ALU_SLT), idle);
      cycle(2'b01, 2'b11, mk(32'hFFFF_FFFF, 32'd1, 5'd0, ALU_SLTU), idle);
      chk("slt", 64'(rsp_r[31:0]), 64'd1);
      cycle(2'b01, 2'b11, mk(32'h8000_0000, 32'd0, 5'd4, ALU_SRA), idle);
      chk("sltu", 64'(rsp_r[31:0]), 64'd0);
      cycle(2'b00, 2'b11, idle, idle);
      chk("sra", 64'(rsp_r[31:0]), 64'hF800_0000);

      // fill both slots, then reset asynchronously mid-cycle
      cycle(2'b11, 2'b00, mk(32'd1, 32'd1, 5'd0, ALU_ADD), mk(32'd2, 32'd2, 5'd0, ALU_ADD));
      cycle(2'b11, 2'b00, mk(32'd1, 32'd1, 5'd0, ALU_ADD), mk(32'd2, 32'd2, 5'd0, ALU_ADD));
      @(posedge clk);
      #1;
      mon_en = 1'b0;
      chk("pre-rst rsp_valid", 64'(rsp_valid), 64'h3);
      #2;
      rst = 1'b1;
      #1;
      chk("async rst rsp_valid", 64'(rsp_valid), 64'h0);
      chk("async rst rsp_r", rsp_r, 64'h0);
      chk("async rst rsp_flags", 64'(rsp_flags), 64'h0);
      chk("async rst busy_cnt", 64'(busy_cnt), 64'h0);
      exp_q[0].delete();
      exp_q[1].delete();
      m_full    = '0;
      m_last    = 1'b1;
      m_busy    = 0;
      req_valid = '0;
      @(negedge clk);
      rst    = 1'b0;
      mon_en = 1'b1;

      // both ports continuously valid and drained
`ifdef PRV32_ALU_ARB_PRIO0_EN
      exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
      exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
      for (int k = 0; k < 4; k++) begin
         cycle(2'b11, 2'b11, mk(32'd3, 32'd3, 5'd0, ALU_SUB), mk(32'hF0, 32'h0F, 5'd0, ALU_XOR));
         chk($sformatf("contention grant %0d", k), 64'(req_ready), 64'(exp_g[k]));
      end
      cycle(2'b10, 2'b11, idle, mk(32'hF0, 32'h0F, 5'd0, ALU_XOR));
      chk("contention busy_cnt", 64'(busy_cnt), 64'd4);
      chk("prio release port1", 64'(req_ready), 64'h2);
      cycle(2'b00, 2'b11, idle, idle);
      chk("sub result", 64'(rsp_r[31:0]), 64'd0);
      chk("sub zf", 64'(rsp_flags[2]), 64'h1);
      chk("xor result", 64'(rsp_r[63:32]), 64'hFF);

      // randomized traffic against the reference model
      for (int n = 0; n < 400; n++) begin
         r0 = mk(rnd_op(), rnd_op(), 5'($urandom_range(0, 31)), fns[$urandom_range(0, 10)]);
         r1 = mk(rnd_op(), rnd_op(), 5'($urandom_range(0, 31)), fns[$urandom_range(0, 10)]);
         cycle(2'($urandom_range(0, 3)),
               {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)}, r0, r1);
      end
      for (int n = 0; n < 3; n++) cycle(2'b00, 2'b11, idle, idle);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
